// File: rtl/switch_mcu_pkg.sv
// switch_mcu_pkg: shared definitions for the switch MCU instruction encoder.
// Holds the symbolic operation enum, RV32I opcode/funct constants and the
// optional field range-check helper used when SWITCH_MCU_ENC_CHECK_EN is set.
package switch_mcu_pkg;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } switch_mcu_op_t;

    localparam logic [5:0] OP_LAST = 6'd46;

    // Major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 values
    localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LB   = 3'b000, F3_LH   = 3'b001, F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100, F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000, F3_SH   = 3'b001, F3_SW   = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL  = 3'b001, F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011, F3_XOR  = 3'b100, F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110, F3_AND  = 3'b111;
    localparam logic [2:0] F3_FENCE   = 3'b000, F3_FENCE_I = 3'b001, F3_PRIV = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001, F3_CSRRS  = 3'b010, F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101, F3_CSRRSI = 3'b110, F3_CSRRCI = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // True when the immediate does not fit the field of the op's format.
    function automatic logic range_fault(input logic [5:0] op, input logic [31:0] imm);
        logic ok_12;
        logic ok_b;
        logic ok_j;
        logic fault;
        ok_12 = (imm[31:11] == 21'h0) || (imm[31:11] == 21'h1F_FFFF);
        ok_b  = !imm[0] && ((imm[31:12] == 20'h0) || (imm[31:12] == 20'hF_FFFF));
        ok_j  = !imm[0] && ((imm[31:20] == 12'h0) || (imm[31:20] == 12'hFFF));
        case (op)
            OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW,
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI:
                fault = !ok_12;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                fault = !ok_b;
            OP_JAL:
                fault = !ok_j;
            OP_LUI, OP_AUIPC:
                fault = (imm[11:0] != 12'h0);
            OP_SLLI, OP_SRLI, OP_SRAI:
                fault = (imm[31:5] != 27'h0);
            default:
                fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/switch_mcu_encoder_fifo.sv
// switch_mcu_encoder_fifo: 2-entry, 33-bit (inst + err) output buffer.
// Head entry is presented combinationally; occupancy is registered and
// exported so the encoder can derive its request-ready from it.
module switch_mcu_encoder_fifo
    import switch_mcu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [32:0] i_data,
    input  logic        i_pop,
    output logic [32:0] o_data,
    output logic [1:0]  o_occ
);

    logic [32:0] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_occ;

    // Storage, pointers and occupancy; all flushed by reset so the output word reads zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= 33'h0;
            r_mem[1] <= 33'h0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/switch_mcu_encoder.sv
// switch_mcu_encoder: RV32I symbolic-instruction to machine-word encoder.
// Combinational encode feeds a 2-entry output buffer; one word per cycle.
// Optional build macro SWITCH_MCU_ENC_CHECK_EN adds immediate range checks to out_err.
module switch_mcu_encoder
    import switch_mcu_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_inst_valid,
    input  logic        in_inst_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] out_count
);

    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_inst;
    logic        w_illegal;
    logic        w_err;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_occ;
    logic [32:0] w_head;
    logic [15:0] r_count;

    // funct3 / funct7 selection for the ops that carry them.
    always_comb begin
        w_f3 = 3'b000;
        w_f7 = F7_BASE;
        case (in_op)
            OP_BEQ:    w_f3 = F3_BEQ;
            OP_BNE:    w_f3 = F3_BNE;
            OP_BLT:    w_f3 = F3_BLT;
            OP_BGE:    w_f3 = F3_BGE;
            OP_BLTU:   w_f3 = F3_BLTU;
            OP_BGEU:   w_f3 = F3_BGEU;
            OP_LB:     w_f3 = F3_LB;
            OP_LH:     w_f3 = F3_LH;
            OP_LW:     w_f3 = F3_LW;
            OP_LBU:    w_f3 = F3_LBU;
            OP_LHU:    w_f3 = F3_LHU;
            OP_SB:     w_f3 = F3_SB;
            OP_SH:     w_f3 = F3_SH;
            OP_SW:     w_f3 = F3_SW;
            OP_ADDI,
            OP_ADD:    w_f3 = F3_ADD;
            OP_SUB:    begin w_f3 = F3_ADD; w_f7 = F7_ALT; end
            OP_SLTI,
            OP_SLT:    w_f3 = F3_SLT;
            OP_SLTIU,
            OP_SLTU:   w_f3 = F3_SLTU;
            OP_XORI,
            OP_XOR:    w_f3 = F3_XOR;
            OP_ORI,
            OP_OR:     w_f3 = F3_OR;
            OP_ANDI,
            OP_AND:    w_f3 = F3_AND;
            OP_SLLI,
            OP_SLL:    w_f3 = F3_SLL;
            OP_SRLI,
            OP_SRL:    w_f3 = F3_SR;
            OP_SRAI,
            OP_SRA:    begin w_f3 = F3_SR; w_f7 = F7_ALT; end
            OP_CSRRW:  w_f3 = F3_CSRRW;
            OP_CSRRS:  w_f3 = F3_CSRRS;
            OP_CSRRC:  w_f3 = F3_CSRRC;
            OP_CSRRWI: w_f3 = F3_CSRRWI;
            OP_CSRRSI: w_f3 = F3_CSRRSI;
            OP_CSRRCI: w_f3 = F3_CSRRCI;
            default:   w_f3 = 3'b000;
        endcase
    end

    // Field packing by instruction format; unknown ops become a flagged NOP.
    always_comb begin
        w_inst    = NOP_WORD;
        w_illegal = 1'b0;
        case (in_op)
            OP_LUI:
                w_inst = {in_imm[31:12], in_rd, OPC_LUI};
            OP_AUIPC:
                w_inst = {in_imm[31:12], in_rd, OPC_AUIPC};
            OP_JAL:
                w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            OP_JALR:
                w_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                          in_imm[4:1], in_imm[11], OPC_BRANCH};
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                w_inst = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_LOAD};
            OP_SB, OP_SH, OP_SW:
                w_inst = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], OPC_STORE};
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI:
                w_inst = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_OP_IMM};
            OP_SLLI, OP_SRLI, OP_SRAI:
                w_inst = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_OP_IMM};
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:
                w_inst = {w_f7, in_rs2, in_rs1, w_f3, in_rd, OPC_OP};
            OP_FENCE:
                w_inst = {in_imm[11:0], in_rs1, F3_FENCE, in_rd, OPC_MISC_MEM};
            OP_FENCE_I:
                w_inst = {12'h000, 5'd0, F3_FENCE_I, 5'd0, OPC_MISC_MEM};
            OP_ECALL:
                w_inst = {12'h000, 5'd0, F3_PRIV, 5'd0, OPC_SYSTEM};
            OP_EBREAK:
                w_inst = {12'h001, 5'd0, F3_PRIV, 5'd0, OPC_SYSTEM};
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI:
                w_inst = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_SYSTEM};
            default: begin
                w_inst    = NOP_WORD;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef SWITCH_MCU_ENC_CHECK_EN
    assign w_err = w_illegal | range_fault(in_op, in_imm);
`else
    assign w_err = w_illegal;
`endif

    assign out_req_ready  = !in_rst && (w_occ != 2'd2);
    assign w_push         = in_req_valid & out_req_ready;
    assign out_inst_valid = (w_occ != 2'd0);
    assign w_pop          = out_inst_valid & in_inst_ready;

    switch_mcu_encoder_fifo u_fifo (
        .i_clk  (in_clk),
        .i_rst  (in_rst),
        .i_push (w_push),
        .i_data ({w_err, w_inst}),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_occ  (w_occ)
    );

    assign out_inst = w_head[31:0];
    assign out_err  = w_head[32];

    // Delivered-word counter, wraps naturally at 16 bits.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_count <= 16'h0;
        end else if (w_pop) begin
            r_count <= r_count + 16'h1;
        end
    end

    assign out_count = r_count;

endmodule
